// File: rtl/mole_round_sched.sv
// Whack-a-mole round scheduler: requests a mole from the selector, shows it
// for a programmable number of seconds, scores hits and misses, and ends the
// level once the selector reports that all moles have been used.
module mole_round_sched #(
  parameter int unsigned SEL_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] interval,
  input  logic       sec_tick,
  output logic       sel_req,
  input  logic       sel_done,
  input  logic [2:0] sel_num,
  input  logic       sel_all,
  input  logic [7:0] hit_pulse,
  output logic [7:0] mole_mask,
  output logic [3:0] secs_left,
  output logic [3:0] hit_cnt,
  output logic [3:0] miss_cnt,
  output logic       score_inc,
  output logic       level_done,
  output logic       sel_err,
  output logic       busy
);

  // Counter only needs to reach SEL_TIMEOUT-1; the timeout fires on that cycle.
  localparam int unsigned   CW      = (SEL_TIMEOUT > 1) ? $clog2(SEL_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(SEL_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_SEL,
    S_SHOW,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last;
  logic          r_sel_req;
  logic [7:0]    r_mask;
  logic [3:0]    r_secs;
  logic [3:0]    r_hit_cnt;
  logic [3:0]    r_miss_cnt;
  logic          r_score_inc;
  logic          r_level_done;
  logic          r_sel_err;
  logic          r_busy;

  logic w_hit;
  logic w_wrong;
  logic w_tmo;

  assign w_hit   = |(hit_pulse & r_mask);
  assign w_wrong = |hit_pulse;
  assign w_tmo   = sec_tick && (r_secs == 4'd1);

  // Level FSM; every output is registered alongside the state transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last       <= 1'b0;
      r_sel_req    <= 1'b0;
      r_mask       <= '0;
      r_secs       <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_score_inc  <= 1'b0;
      r_level_done <= 1'b0;
      r_sel_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sel_req    <= 1'b0;
      r_score_inc  <= 1'b0;
      r_level_done <= 1'b0;
      r_sel_err    <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state <= S_IDLE;
        r_mask  <= '0;
        r_secs  <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_hit_cnt  <= '0;
              r_miss_cnt <= '0;
              r_secs     <= '0;
              r_sel_req  <= 1'b1;
              r_busy     <= 1'b1;
              r_state    <= S_REQ;
            end
          end
          S_REQ: begin
            r_cnt   <= '0;
            r_state <= S_WAIT_SEL;
          end
          S_WAIT_SEL: begin
            if (sel_done) begin
              r_mask  <= 8'b0000_0001 << sel_num;
              r_secs  <= (interval == 4'd0) ? 4'd1 : interval;
              r_last  <= sel_all;
              r_state <= S_SHOW;
            end else if (r_cnt == TO_LAST) begin
              r_sel_err <= 1'b1;
              r_mask    <= '0;
              r_busy    <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_SHOW: begin
            if (w_hit || w_wrong || w_tmo) begin
              if (w_hit) begin
                if (r_hit_cnt != 4'hF) r_hit_cnt <= r_hit_cnt + 4'd1;
                r_score_inc <= 1'b1;
              end else if (r_miss_cnt != 4'hF) begin
                r_miss_cnt <= r_miss_cnt + 4'd1;
              end
              r_mask <= '0;
              r_secs <= '0;
              if (r_last) begin
                r_level_done <= 1'b1;
                r_state      <= S_DONE;
              end else begin
                r_sel_req <= 1'b1;
                r_state   <= S_REQ;
              end
            end else if (sec_tick) begin
              r_secs <= r_secs - 4'd1;
            end
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_mask  <= '0;
            r_secs  <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign sel_req    = r_sel_req;
  assign mole_mask  = r_mask;
  assign secs_left  = r_secs;
  assign hit_cnt    = r_hit_cnt;
  assign miss_cnt   = r_miss_cnt;
  assign score_inc  = r_score_inc;
  assign level_done = r_level_done;
  assign sel_err    = r_sel_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_mole_round_sched.sv
// Scoreboard bench for mole_round_sched: stimulus pushes the expected output
// snapshot of every cycle that should show a strobe, a mask change or a probe;
// the monitor pops and compares on each such cycle.
module tb_mole_round_sched;

  typedef logic [24:0] snap_t;
  typedef struct {
    string name;
    snap_t v;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] interval;
  logic       sec_tick;
  logic       sel_req;
  logic       sel_done;
  logic [2:0] sel_num;
  logic       sel_all;
  logic [7:0] hit_pulse;
  logic [7:0] mole_mask;
  logic [3:0] secs_left;
  logic [3:0] hit_cnt;
  logic [3:0] miss_cnt;
  logic       score_inc;
  logic       level_done;
  logic       sel_err;
  logic       busy;

  logic       probe;
  logic       probe_d;
  logic       mon_en;
  logic [7:0] prev_mask;
  int         n_pass;
  int         n_total;
  exp_t       sbq[$];

  mole_round_sched #(.SEL_TIMEOUT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .interval  (interval),
    .sec_tick  (sec_tick),
    .sel_req   (sel_req),
    .sel_done  (sel_done),
    .sel_num   (sel_num),
    .sel_all   (sel_all),
    .hit_pulse (hit_pulse),
    .mole_mask (mole_mask),
    .secs_left (secs_left),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
    .score_inc (score_inc),
    .level_done(level_done),
    .sel_err   (sel_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t ex(input logic sr, input logic si, input logic ld,
                               input logic se, input logic bz, input logic [7:0] m,
                               input logic [3:0] s, input logic [3:0] h,
                               input logic [3:0] ms);
    return {sr, si, ld, se, bz, m, s, h, ms};
  endfunction

  function automatic string fmt(input snap_t v);
    return $sformatf("sel_req=%b score_inc=%b level_done=%b sel_err=%b busy=%b mask=%h secs=%0d hit=%0d miss=%0d",
                     v[24], v[23], v[22], v[21], v[20], v[19:12], v[11:8], v[7:4], v[3:0]);
  endfunction

  task automatic push(input string n, input snap_t v);
    exp_t e;
    e.name = n;
    e.v    = v;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sel(input logic [2:0] n, input logic all, input logic [3:0] iv,
                        input snap_t e, input string name);
    interval = iv;
    sel_num  = n;
    sel_all  = all;
    sel_done = 1'b1;
    push(name, e);
    tick();
    sel_done = 1'b0;
    sel_all  = 1'b0;
  endtask

  task automatic hit_in(input logic [7:0] hp, input logic st, input snap_t e,
                        input string name);
    hit_pulse = hp;
    sec_tick  = st;
    push(name, e);
    tick();
    hit_pulse = '0;
    sec_tick  = 1'b0;
  endtask

  task automatic probe_chk(input logic st, input snap_t e, input string name);
    sec_tick = st;
    probe    = 1'b1;
    push(name, e);
    tick();
    sec_tick = 1'b0;
    probe    = 1'b0;
  endtask

  // Probe request is delayed one edge so it lines up with stimulus effects.
  initial begin
    probe_d = 1'b0;
    forever begin
      @(posedge clk);
      probe_d = probe;
    end
  end

  // Monitor: compare every interesting cycle against the scoreboard head.
  initial begin
    exp_t  e;
    snap_t s;
    prev_mask = '0;
    forever begin
      @(negedge clk);
      s = {sel_req, score_inc, level_done, sel_err, busy, mole_mask, secs_left, hit_cnt, miss_cnt};
      if (mon_en && (probe_d || sel_req || score_inc || level_done || sel_err ||
                     (mole_mask != prev_mask))) begin
        n_total++;
        if (sbq.size() == 0) begin
          $display("FAIL unexpected_event: got %s, required no event", fmt(s));
        end else begin
          e = sbq.pop_front();
          if (s === e.v) n_pass++;
          else $display("FAIL %s: got %s, required %s", e.name, fmt(s), fmt(e.v));
        end
      end
      prev_mask = mole_mask;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required finish before 100000");
    $fatal(1);
  end

  initial begin
    exp_t e;
    logic [7:0] m;
    n_pass    = 0;
    n_total   = 0;
    mon_en    = 1'b0;
    probe     = 1'b0;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    interval  = 4'd3;
    sec_tick  = 1'b0;
    sel_done  = 1'b0;
    sel_num   = '0;
    sel_all   = 1'b0;
    hit_pulse = '0;
    repeat (3) tick();
    rst    = 1'b0;
    mon_en = 1'b1;
    probe_chk(1'b0, ex(0,0,0,0,0,8'h00,0,0,0), "reset_state");

    // A: timeout miss, hit, wrong button, interval 0, abort, idle inputs
    start = 1'b1;
    push("A_start", ex(1,0,0,0,1,8'h00,0,0,0));
    tick();
    start = 1'b0;
    tick();
    tick();
    do_sel(3'd5, 1'b0, 4'd3, ex(0,0,0,0,1,8'h20,3,0,0), "A_sel5");
    probe_chk(1'b1, ex(0,0,0,0,1,8'h20,2,0,0), "A_tick3to2");
    probe_chk(1'b1, ex(0,0,0,0,1,8'h20,1,0,0), "A_tick2to1");
    hit_in(8'h00, 1'b1, ex(1,0,0,0,1,8'h00,0,0,1), "A_timeout_miss");
    tick();
    do_sel(3'd5, 1'b0, 4'd3, ex(0,0,0,0,1,8'h20,3,0,1), "A_sel5b");
    hit_in(8'h20, 1'b0, ex(1,1,0,0,1,8'h00,0,1,1), "A_hit");
    tick();
    do_sel(3'd2, 1'b0, 4'd0, ex(0,0,0,0,1,8'h04,1,1,1), "A_sel2_iv0");
    hit_in(8'h01, 1'b0, ex(1,0,0,0,1,8'h00,0,1,2), "A_wrong_button");
    tick();
    do_sel(3'd0, 1'b0, 4'd0, ex(0,0,0,0,1,8'h01,1,1,2), "A_sel0_iv0");
    hit_in(8'h00, 1'b1, ex(1,0,0,0,1,8'h00,0,1,3), "A_iv0_one_tick");
    tick();
    do_sel(3'd7, 1'b0, 4'd5, ex(0,0,0,0,1,8'h80,5,1,3), "A_sel7");
    abort = 1'b1;
    push("A_abort", ex(0,0,0,0,0,8'h00,0,1,3));
    tick();
    abort     = 1'b0;
    hit_pulse = 8'hFF;
    sel_done  = 1'b1;
    sel_num   = 3'd1;
    sec_tick  = 1'b1;
    tick();
    hit_pulse = '0;
    sel_done  = 1'b0;
    sec_tick  = 1'b0;
    probe_chk(1'b0, ex(0,0,0,0,0,8'h00,0,1,3), "A_idle_hold");

    // B: full level of eight hits, start wins over abort, last hit on final tick
    start = 1'b1;
    abort = 1'b1;
    push("B_start", ex(1,0,0,0,1,8'h00,0,0,0));
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      m = 8'h01 << k;
      do_sel(3'(k), (k == 7), 4'd2, ex(0,0,0,0,1,m,2,4'(k),0), $sformatf("B_sel%0d", k));
      if (k == 7) begin
        probe_chk(1'b1, ex(0,0,0,0,1,8'h80,1,7,0), "B_tick_last");
        hit_in(8'h80, 1'b1, ex(0,1,1,0,1,8'h00,0,8,0), "B_hit_and_tick");
      end else begin
        hit_in(m, 1'b0, ex(1,1,0,0,1,8'h00,0,4'(k + 1),0), $sformatf("B_hit%0d", k));
      end
    end
    probe_chk(1'b0, ex(0,0,0,0,0,8'h00,0,8,0), "B_idle_after_done");

    // C: selector never answers
    start = 1'b1;
    push("C_start", ex(1,0,0,0,1,8'h00,0,0,0));
    tick();
    start = 1'b0;
    repeat (17) tick();
    push("C_sel_err", ex(0,0,0,1,0,8'h00,0,0,0));
    tick();
    tick();

    // D: start ignored while busy, then reset in SHOW
    start = 1'b1;
    push("D_start", ex(1,0,0,0,1,8'h00,0,0,0));
    tick();
    start = 1'b0;
    tick();
    do_sel(3'd3, 1'b0, 4'd4, ex(0,0,0,0,1,8'h08,4,0,0), "D_sel3");
    start = 1'b1;
    tick();
    start = 1'b0;
    hit_in(8'h08, 1'b0, ex(1,1,0,0,1,8'h00,0,1,0), "D_hit");
    tick();
    do_sel(3'd6, 1'b0, 4'd4, ex(0,0,0,0,1,8'h40,4,1,0), "D_sel6");
    rst       = 1'b1;
    hit_pulse = 8'h40;
    push("D_reset_in_show", ex(0,0,0,0,0,8'h00,0,0,0));
    tick();
    rst       = 1'b0;
    hit_pulse = '0;
    repeat (5) tick();

    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_total++;
      $display("FAIL %s: got no event, required %s", e.name, fmt(e.v));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
